fifo_access_ctrl: RTL and testbench
===================================

Name: fifo_access_ctrl

Overview:
- Controller that shares one Synchronous_FIFO instance (8-bit data, 16 entries, 4-bit threshold) between two producers and drains it in bursts to one consumer.
- Write side: round-robin arbitration of two valid/ready producers onto the FIFO push port.
- Read side: FSM issues pops when the FIFO threshold trigger fires or a flush is requested, and presents the data on a valid/ready output.
- Sits directly beside the FIFO; all FIFO control pins are driven only by this block.

Parameters:
- DATA_W, 8, data width of producers, FIFO and consumer.
- BURST_LEN, 8, maximum pops per drain burst (1..16).
- THR_W, 4, width of the threshold configuration.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  reset, asynchronous assert, active-low; deasserted synchronously to clk externally.
- cfg_threshold  in  THR_W  FIFO threshold; registered, drives fifo_threshold.
- flush  in  1  single-cycle pulse; drains the FIFO until empty.
- p0_valid / p0_data / p0_ready  in / in / out  1 / DATA_W / 1  producer 0 handshake.
- p1_valid / p1_data / p1_ready  in / in / out  1 / DATA_W / 1  producer 1 handshake.
- m_valid / m_data / m_ready  out / out / in  1 / DATA_W / 1  consumer handshake.
- fifo_en, fifo_push, fifo_pop  out  1 each  FIFO control.
- fifo_din  out  DATA_W  FIFO write data.
- fifo_threshold  out  THR_W  FIFO threshold.
- fifo_empty, fifo_full, fifo_overrun, fifo_underrun, fifo_thre_trigger  in  1 each  FIFO status.
- fifo_dout  in  DATA_W  FIFO read data, valid the cycle after fifo_pop.
- busy  out  1  high while the read FSM is not in IDLE.
- err  out  1  sticky: set if fifo_overrun or fifo_underrun is ever seen; cleared only by reset.

Behaviour:
- Reset (rst low, async) forces the following values:
  - All outputs 0, except fifo_en = 1.
  - fifo_threshold = 0, err = 0, m_data = 0.
  - rr_last = 1, so producer 0 wins first.
  - FSM in IDLE, flush_pend = 0.
- fifo_en is 1 at all times out of reset.
- Write arbitration (combinational grant, registered pointer):
  - grant = requester with valid; if both valid, the one not equal to rr_last.
  - pX_ready = (grant == X) & !fifo_full.
  - fifo_push = any accepted; fifo_din = granted data.
  - rr_last updates to X only on an accepted transfer.
  - fifo_full high: no ready, no push, pointer unchanged.
- Read FSM, states IDLE, POP, CAPT, HOLD:
  - IDLE -> POP when (fifo_thre_trigger | flush_pend) & !fifo_empty. Load burst_cnt = BURST_LEN, or 16 if flush_pend.
  - POP: fifo_pop = 1 for exactly one cycle -> CAPT.
  - CAPT: m_data <= fifo_dout, m_valid <= 1 -> HOLD.
  - HOLD: m_valid and m_data are held stable until m_ready. On m_valid & m_ready, m_valid <= 0 and burst_cnt decrements. Then:
    - -> POP if burst_cnt - 1 != 0 and !fifo_empty;
    - otherwise -> IDLE.
- Latency: 3 cycles minimum per byte (POP, CAPT, HOLD with m_ready = 1); first m_valid appears 2 cycles after leaving IDLE.
- Flush:
  - A flush pulse sets flush_pend.
  - flush_pend clears when the FSM returns to IDLE with fifo_empty = 1.
  - A flush during a burst extends that burst to empty.
  - A flush while the FIFO is empty clears flush_pend on the next cycle.
- Simultaneous push and pop in the same cycle is legal and is passed through unchanged.
- fifo_pop is never issued while fifo_empty = 1, so underrun cannot be caused by this block. Overrun likewise cannot be caused (push gated by full). err flags FIFO misbehaviour.
- Reset mid-burst: the FSM returns to IDLE immediately and m_valid drops asynchronously. FIFO contents belong to the FIFO's own reset.

Decomposition:
- Shared package fifo_ctrl_pkg:
  - read FSM state encoding (IDLE = 0, POP = 1, CAPT = 2, HOLD = 3);
  - DATA_W, THR_W and FIFO_DEPTH = 16 constants.
- One sub-module, rr_arb2: two-requester round-robin grant with pointer register, reusable elsewhere.
- The read FSM stays in the top.

Test Plan:
- Reset: hold rst low 5 cycles with random inputs -> all outputs at the reset values above and fifo_en = 1. Assert rst mid-HOLD -> m_valid = 0 in the same cycle.
- Round-robin: both producers valid, p0 sends A0..A3 and p1 sends B0..B3, m_ready = 0, threshold 15 -> FIFO push order A0, B0, A1, B1, A2, B2, A3, B3.
- Back-pressure: fill 16 entries, fifo_full = 1 -> p0_ready = p1_ready = 0 and no fifo_push. After one pop, exactly one push is accepted, from the producer that did not win last.
- Threshold burst: threshold 10, push 10 bytes 0x01..0x0A, m_ready = 1 -> exactly 8 bytes 0x01..0x08 out in order, one fifo_pop per 3 cycles, FSM back in IDLE with 2 entries left.
- Flush: 3 entries 0x11, 0x22, 0x33, trigger low, pulse flush -> all 3 delivered, burst ends on fifo_empty, busy = 0, and no further pop.
- Consumer stall: m_ready low 5 cycles in HOLD -> m_data stable and no extra fifo_pop. err stays 0 in all scenarios.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg
//   Shared constants for the FIFO access controller: datapath widths, FIFO
//   depth, burst counter width and the read-FSM state encoding.
package fifo_ctrl_pkg;

  localparam int DATA_W     = 8;
  localparam int THR_W      = 4;
  localparam int FIFO_DEPTH = 16;
  // Burst counter must hold FIFO_DEPTH (16), hence 5 bits.
  localparam int CNT_W      = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_POP  = 2'd1;
  localparam logic [1:0] ST_CAPT = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

endpackage

// File: rtl/fifo_access_ctrl_rr_arb2.sv
// rr_arb2
//   Two-requester round-robin arbiter. The grant is combinational; the
//   "last winner" pointer is registered and only moves on a granted cycle.
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   req0/req1  request inputs
//   en         grant enable (a grant only happens when en = 1)
//   gnt0/gnt1  one-hot (or zero) grant outputs, already qualified by en
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic en,
  output logic gnt0,
  output logic gnt1
);

  logic last_q;
  logic last_d;
  logic pick1;

  always_comb begin
    // With both requesting, requester 1 wins only if 0 won last time.
    pick1  = req1 & (~req0 | ~last_q);
    gnt1   = en & pick1;
    gnt0   = en & req0 & ~pick1;
    last_d = last_q;
    if (gnt0) begin
      last_d = 1'b0;
    end else if (gnt1) begin
      last_d = 1'b1;
    end
  end

  // Reset to 1 so requester 0 wins the first contested cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/fifo_access_ctrl.sv
// fifo_access_ctrl
//   Shares one synchronous FIFO between two producers (round-robin onto the
//   push port) and drains it in bursts to a single valid/ready consumer.
//   A burst starts on the FIFO threshold trigger or a pending flush.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   cfg_threshold            threshold config, registered onto fifo_threshold
//   flush                    one-cycle pulse: drain the FIFO until empty
//   p0_*/p1_*                producer valid/data/ready
//   m_*                      consumer valid/data/ready
//   fifo_en/push/pop/din/threshold   FIFO control
//   fifo_empty/full/overrun/underrun/thre_trigger/dout   FIFO status/data
//   busy                     read FSM not idle
//   err                      sticky FIFO overrun/underrun flag
module fifo_access_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int DATA_W    = fifo_ctrl_pkg::DATA_W,
  parameter int BURST_LEN = 8,
  parameter int THR_W     = fifo_ctrl_pkg::THR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [THR_W-1:0]  cfg_threshold,
  input  logic              flush,
  input  logic              p0_valid,
  input  logic [DATA_W-1:0] p0_data,
  output logic              p0_ready,
  input  logic              p1_valid,
  input  logic [DATA_W-1:0] p1_data,
  output logic              p1_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              fifo_en,
  output logic              fifo_push,
  output logic              fifo_pop,
  output logic [DATA_W-1:0] fifo_din,
  output logic [THR_W-1:0]  fifo_threshold,
  input  logic              fifo_empty,
  input  logic              fifo_full,
  input  logic              fifo_overrun,
  input  logic              fifo_underrun,
  input  logic              fifo_thre_trigger,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              busy,
  output logic              err
);

  logic              gnt0;
  logic              gnt1;
  logic              arb_en;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  burst_q, burst_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              flush_pend_q, flush_pend_d;
  logic [THR_W-1:0]  thr_q, thr_d;
  logic              err_q, err_d;

  // ---------------- write side ----------------
  // Gating with rst keeps ready/push low while reset is held.
  assign arb_en = ~fifo_full & rst;

  rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .req0 (p0_valid),
    .req1 (p1_valid),
    .en   (arb_en),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  assign p0_ready  = gnt0;
  assign p1_ready  = gnt1;
  assign fifo_push = gnt0 | gnt1;
  assign fifo_din  = gnt0 ? p0_data : (gnt1 ? p1_data : '0);

  // ---------------- read side ----------------
  always_comb begin
    state_d   = state_q;
    burst_d   = burst_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    fifo_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((fifo_thre_trigger | flush_pend_q) & ~fifo_empty) begin
          state_d = ST_POP;
          burst_d = flush_pend_q ? CNT_W'(FIFO_DEPTH) : CNT_W'(BURST_LEN);
        end
      end
      ST_POP: begin
        fifo_pop = 1'b1;
        state_d  = ST_CAPT;
      end
      ST_CAPT: begin
        // FIFO read data is valid the cycle after the pop.
        m_data_d  = fifo_dout;
        m_valid_d = 1'b1;
        state_d   = ST_HOLD;
      end
      default: begin // ST_HOLD
        if (m_ready) begin
          m_valid_d = 1'b0;
          burst_d   = burst_q - CNT_W'(1);
          // A pending flush keeps the burst going until the FIFO is empty.
          if (~fifo_empty & ((burst_d != '0) | flush_pend_q | flush)) begin
            state_d = ST_POP;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
    endcase

    flush_pend_d = flush_pend_q;
    if (flush) begin
      flush_pend_d = 1'b1;
    end else if ((state_q == ST_IDLE) & fifo_empty) begin
      flush_pend_d = 1'b0;
    end

    thr_d = cfg_threshold;
    err_d = err_q | fifo_overrun | fifo_underrun;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      burst_q      <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      flush_pend_q <= 1'b0;
      thr_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_q      <= burst_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      flush_pend_q <= flush_pend_d;
      thr_q        <= thr_d;
      err_q        <= err_d;
    end
  end

  assign fifo_en        = 1'b1;
  assign m_valid        = m_valid_q;
  assign m_data         = m_data_q;
  assign fifo_threshold = thr_q;
  assign busy           = (state_q != ST_IDLE);
  assign err            = err_q;

endmodule

// File: tb/tb_fifo_access_ctrl.sv
// tb_fifo_access_ctrl
//   Self-checking bench for fifo_access_ctrl with a behavioural 16-entry FIFO
//   attached to its control pins. Trigger model: count >= threshold, and a
//   threshold of 0 disables the trigger.
module tb_fifo_access_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cfg_threshold;
  logic       flush;
  logic       p0_valid, p0_ready, p1_valid, p1_ready;
  logic [7:0] p0_data, p1_data;
  logic       m_valid, m_ready;
  logic [7:0] m_data;
  logic       fifo_en, fifo_push, fifo_pop;
  logic [7:0] fifo_din, fifo_dout;
  logic [3:0] fifo_threshold;
  logic       fifo_empty, fifo_full, fifo_overrun, fifo_underrun, fifo_thre_trigger;
  logic       busy, err;

  always #5 clk = ~clk;

  fifo_access_ctrl dut (
    .clk(clk), .rst(rst), .cfg_threshold(cfg_threshold), .flush(flush),
    .p0_valid(p0_valid), .p0_data(p0_data), .p0_ready(p0_ready),
    .p1_valid(p1_valid), .p1_data(p1_data), .p1_ready(p1_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .fifo_en(fifo_en), .fifo_push(fifo_push), .fifo_pop(fifo_pop),
    .fifo_din(fifo_din), .fifo_threshold(fifo_threshold),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_overrun(fifo_overrun),
    .fifo_underrun(fifo_underrun), .fifo_thre_trigger(fifo_thre_trigger),
    .fifo_dout(fifo_dout), .busy(busy), .err(err)
  );

  // ---------------- FIFO model ----------------
  logic [7:0] mq[$];
  int         mcnt;
  logic [7:0] mdout;
  logic       ov, un, force_full;

  assign fifo_empty        = (mcnt == 0);
  assign fifo_full         = (mcnt == 16) || force_full;
  assign fifo_thre_trigger = (fifo_threshold != 4'd0) && (mcnt >= int'(fifo_threshold));
  assign fifo_dout         = mdout;
  assign fifo_overrun      = ov;
  assign fifo_underrun     = un;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      mcnt  <= 0;
      mdout <= 8'h00;
      ov    <= 1'b0;
      un    <= 1'b0;
    end else begin
      ov <= fifo_push && !fifo_pop && (mq.size() == 16);
      un <= fifo_pop && (mq.size() == 0);
      if (fifo_pop && mq.size() != 0) mdout <= mq.pop_front();
      if (fifo_push && mq.size() < 16) mq.push_back(fifo_din);
      mcnt <= mq.size();
    end
  end

  // ---------------- monitors (mid-cycle sampling) ----------------
  int         cyc = 0;
  int         pop_cnt, acc0, acc1;
  int         pop_cyc[$];
  logic [7:0] outq[$];

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (fifo_pop) begin
        pop_cnt++;
        pop_cyc.push_back(cyc);
      end
      if (m_valid && m_ready) outq.push_back(m_data);
      if (p0_valid && p0_ready) acc0++;
      if (p1_valid && p1_ready) acc1++;
    end
  end

  // ---------------- checking helpers ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    pop_cnt = 0; acc0 = 0; acc1 = 0;
    pop_cyc.delete();
    outq.delete();
  endtask

  task automatic idle_inputs();
    flush = 0; p0_valid = 0; p1_valid = 0; p0_data = 0; p1_data = 0;
    m_ready = 0; force_full = 0;
  endtask

  // Hold reset with random inputs, check reset values, release with cfg thr.
  task automatic do_reset(input logic [3:0] thr);
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      p0_valid = 1'($urandom); p1_valid = 1'($urandom);
      p0_data = 8'($urandom); p1_data = 8'($urandom);
      m_ready = 1'($urandom); flush = 1'($urandom);
      cfg_threshold = 4'($urandom);
      tick();
    end
    chk("rst p0_ready", p0_ready, 0);
    chk("rst p1_ready", p1_ready, 0);
    chk("rst m_valid", m_valid, 0);
    chk("rst m_data", m_data, 0);
    chk("rst fifo_push", fifo_push, 0);
    chk("rst fifo_pop", fifo_pop, 0);
    chk("rst fifo_din", fifo_din, 0);
    chk("rst fifo_threshold", fifo_threshold, 0);
    chk("rst busy", busy, 0);
    chk("rst err", err, 0);
    chk("rst fifo_en", fifo_en, 1);
    idle_inputs();
    cfg_threshold = thr;
    rst = 1;
    tick();
    clear_mon();
  endtask

  // ---------------- arbitration vector table ----------------
  typedef struct {
    logic       v0, v1, ff;
    logic [7:0] d0, d1;
    logic       er0, er1, epush;
    logic [7:0] edin;
  } arb_vec_t;

  arb_vec_t   vt[14];
  logic [7:0] exp_order[11];
  logic [7:0] exp_bp[17];

  initial begin
    rst = 0;
    idle_inputs();
    cfg_threshold = 0;

    //        v0 v1 ff  d0     d1     r0 r1 push din
    vt[0]  = '{1, 1, 0, 8'hA0, 8'hB0, 1, 0, 1, 8'hA0};
    vt[1]  = '{1, 1, 0, 8'hA1, 8'hB0, 0, 1, 1, 8'hB0};
    vt[2]  = '{1, 1, 0, 8'hA1, 8'hB1, 1, 0, 1, 8'hA1};
    vt[3]  = '{1, 1, 1, 8'hA2, 8'hB1, 0, 0, 0, 8'h00};
    vt[4]  = '{1, 1, 0, 8'hA2, 8'hB1, 0, 1, 1, 8'hB1};
    vt[5]  = '{1, 1, 0, 8'hA2, 8'hB2, 1, 0, 1, 8'hA2};
    vt[6]  = '{1, 1, 0, 8'hA3, 8'hB2, 0, 1, 1, 8'hB2};
    vt[7]  = '{1, 1, 0, 8'hA3, 8'hB3, 1, 0, 1, 8'hA3};
    vt[8]  = '{0, 1, 0, 8'hA4, 8'hB3, 0, 1, 1, 8'hB3};
    vt[9]  = '{0, 0, 0, 8'hA4, 8'hB4, 0, 0, 0, 8'h00};
    vt[10] = '{0, 1, 0, 8'hA4, 8'hB4, 0, 1, 1, 8'hB4};
    vt[11] = '{1, 1, 0, 8'hA4, 8'hB5, 1, 0, 1, 8'hA4};
    vt[12] = '{1, 0, 1, 8'hA5, 8'hB5, 0, 0, 0, 8'h00};
    vt[13] = '{1, 0, 0, 8'hA5, 8'hB5, 1, 0, 1, 8'hA5};
    exp_order = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2, 8'hA3, 8'hB3,
                  8'hB4, 8'hA4, 8'hA5};
    // Back-pressure: alternating fill then the one extra p0 push after a pop.
    for (int k = 0; k < 16; k++)
      exp_bp[k] = (k % 2 == 0) ? 8'(8'h40 + k / 2) : 8'(8'h60 + k / 2);
    exp_bp[16] = 8'h48;

    // ---------- reset + round-robin table ----------
    do_reset(4'd15);
    for (int i = 0; i < 14; i++) begin
      p0_valid = vt[i].v0; p1_valid = vt[i].v1; force_full = vt[i].ff;
      p0_data = vt[i].d0; p1_data = vt[i].d1;
      #1;
      chk($sformatf("arb[%0d] p0_ready", i), p0_ready, vt[i].er0);
      chk($sformatf("arb[%0d] p1_ready", i), p1_ready, vt[i].er1);
      chk($sformatf("arb[%0d] fifo_push", i), fifo_push, vt[i].epush);
      if (vt[i].epush) chk($sformatf("arb[%0d] fifo_din", i), fifo_din, vt[i].edin);
      $display("arb vector %0d: v=%b%b ff=%b push=%b din=%h", i, vt[i].v0, vt[i].v1,
               vt[i].ff, fifo_push, fifo_din);
      tick();
    end
    idle_inputs();
    tick();
    chk("rr fifo count", mq.size(), 11);
    for (int i = 0; i < 11; i++)
      if (i < mq.size()) chk($sformatf("rr order[%0d]", i), mq[i], exp_order[i]);
    chk("rr no pop", pop_cnt, 0);
    chk("rr err", err, 0);

    // ---------- back-pressure + consumer stall ----------
    do_reset(4'd0);
    p0_valid = 1; p1_valid = 1;
    for (int c = 0; c < 40 && (acc0 + acc1) < 16; c++) begin
      p0_data = 8'(8'h40 + acc0);
      p1_data = 8'(8'h60 + acc1);
      tick();
    end
    p0_data = 8'(8'h40 + acc0);
    p1_data = 8'(8'h60 + acc1);
    chk("bp accepted", acc0 + acc1, 16);
    chk("bp full", fifo_full, 1);
    chk("bp p0_ready", p0_ready, 0);
    chk("bp p1_ready", p1_ready, 0);
    chk("bp fifo_push", fifo_push, 0);
    tick(); tick();
    chk("bp no push while full", acc0 + acc1, 16);
    flush = 1;
    tick();
    flush = 0;
    for (int c = 0; c < 10 && !m_valid; c++) tick();
    for (int c = 0; c < 3; c++) begin
      p0_data = 8'(8'h40 + acc0);
      p1_data = 8'(8'h60 + acc1);
      tick();
    end
    chk("bp p0 extra push", acc0, 9);
    chk("bp p1 no extra", acc1, 8);
    chk("bp one pop", pop_cnt, 1);
    for (int c = 0; c < 5; c++) begin
      chk("stall m_valid", m_valid, 1);
      chk("stall m_data", m_data, 8'h40);
      tick();
    end
    chk("stall no extra pop", pop_cnt, 1);
    p0_valid = 0; p1_valid = 0; m_ready = 1;
    for (int c = 0; c < 100 && (busy || outq.size() < 17); c++) tick();
    tick(); tick(); tick();
    chk("bp delivered", outq.size(), 17);
    for (int k = 0; k < 17; k++)
      if (k < outq.size()) chk($sformatf("bp out[%0d]", k), outq[k], exp_bp[k]);
    chk("bp pops", pop_cnt, 17);
    chk("bp busy", busy, 0);
    chk("bp err", err, 0);
    $display("back-pressure: delivered %0d bytes, pops %0d", outq.size(), pop_cnt);

    // ---------- threshold burst ----------
    do_reset(4'd10);
    m_ready = 1;
    for (int i = 0; i < 10; i++) begin
      p0_valid = 1; p0_data = 8'(i + 1);
      #1;
      chk($sformatf("thr push %0d ready", i), p0_ready, 1);
      tick();
    end
    p0_valid = 0;
    for (int c = 0; c < 40; c++) tick();
    chk("thr delivered", outq.size(), 8);
    for (int k = 0; k < 8; k++)
      if (k < outq.size()) chk($sformatf("thr out[%0d]", k), outq[k], 8'(k + 1));
    chk("thr pops", pop_cnt, 8);
    for (int k = 1; k < pop_cyc.size(); k++)
      chk($sformatf("thr pop spacing %0d", k), pop_cyc[k] - pop_cyc[k-1], 3);
    chk("thr left in fifo", mcnt, 2);
    chk("thr busy", busy, 0);
    chk("thr err", err, 0);
    $display("threshold burst: delivered %0d bytes, %0d left", outq.size(), mcnt);

    // ---------- flush ----------
    do_reset(4'd0);
    m_ready = 1;
    p1_valid = 1; p1_data = 8'h11; tick();
    p1_data = 8'h22; tick();
    p1_data = 8'h33; tick();
    p1_valid = 0;
    tick();
    chk("flush idle before pulse", pop_cnt, 0);
    flush = 1;
    tick();
    flush = 0;
    for (int c = 0; c < 30; c++) tick();
    chk("flush delivered", outq.size(), 3);
    if (outq.size() == 3) begin
      chk("flush out0", outq[0], 8'h11);
      chk("flush out1", outq[1], 8'h22);
      chk("flush out2", outq[2], 8'h33);
    end
    chk("flush pops", pop_cnt, 3);
    chk("flush busy", busy, 0);
    p1_valid = 1; p1_data = 8'h44; tick();
    p1_valid = 0;
    for (int c = 0; c < 10; c++) tick();
    chk("flush pend cleared", pop_cnt, 3);
    chk("flush fifo count", mcnt, 1);
    chk("flush err", err, 0);
    $display("flush: delivered %0d bytes, pops %0d", outq.size(), pop_cnt);

    // ---------- reset mid-HOLD ----------
    m_ready = 0;
    flush = 1;
    tick();
    flush = 0;
    for (int c = 0; c < 10 && !m_valid; c++) tick();
    chk("hold m_valid before rst", m_valid, 1);
    chk("hold m_data before rst", m_data, 8'h44);
    #2;
    rst = 0;
    #1;
    chk("async rst m_valid", m_valid, 0);
    chk("async rst busy", busy, 0);
    chk("async rst m_data", m_data, 0);
    $display("reset mid-hold: m_valid=%b busy=%b", m_valid, busy);
    tick();
    rst = 1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
